// File: rtl/op_imm_issue.sv
`default_nettype none
// ============================================================================
// Module      : op_imm_issue
// Description : Issue stage for RV32I OP-IMM instructions (ADDI, SLTI, SLTIU,
//               XORI, ORI, ANDI). Decodes the offered instruction word, reads
//               rs1 from the register file, sign-extends the 12-bit immediate
//               and presents registered operands to alu_register_immediate.
//               A 32-entry busy scoreboard (cleared by writeback) stalls
//               read-after-write hazards. Unsupported words are consumed and
//               flagged with a one-cycle illegal_instruction pulse.
// Ports       :
//   clock, reset_n                 rising-edge clock, async active-low reset
//   instruction_valid/instruction  offered instruction word
//   instruction_ready              combinational accept indication
//   rf_read_address/rf_read_data   same-cycle register-file read of rs1
//   wb_valid/wb_rd                 writeback commit, clears busy[wb_rd]
//   alu_register_immediate_enable  one-cycle issue pulse to the ALU
//   funct3/rs1/immediate12_itype   registered ALU operands
//   rd_index                       registered destination index
//   illegal_instruction            one-cycle pulse for unsupported words
//   issued_count                   instructions issued since reset
// Revision    : 1.0 - initial release
// ============================================================================
module op_imm_issue #(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   instruction_valid,
  input  logic [31:0]            instruction,
  output logic                   instruction_ready,
  output logic [4:0]             rf_read_address,
  input  logic [XLEN-1:0]        rf_read_data,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic                   alu_register_immediate_enable,
  output logic [2:0]             funct3,
  output logic [XLEN-1:0]        rs1,
  output logic [XLEN-1:0]        immediate12_itype,
  output logic [4:0]             rd_index,
  output logic                   illegal_instruction,
  output logic [COUNT_WIDTH-1:0] issued_count
);

  localparam logic [6:0] C_OPCODE_OP_IMM = 7'b0010011;

  // Field decode
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1_index;
  logic [XLEN-1:0] w_immediate;

  assign w_opcode    = instruction[6:0];
  assign w_rd        = instruction[11:7];
  assign w_funct3    = instruction[14:12];
  assign w_rs1_index = instruction[19:15];
  assign w_immediate = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

  assign rf_read_address = w_rs1_index;

  // Registered state
  logic [31:0]            r_busy;
  logic                   r_enable;
  logic                   r_illegal;
  logic [2:0]             r_funct3;
  logic [XLEN-1:0]        r_rs1;
  logic [XLEN-1:0]        r_immediate;
  logic [4:0]             r_rd_index;
  logic [COUNT_WIDTH-1:0] r_issued_count;

  // Handshake / classification
  logic        w_hazard;
  logic        w_accept;
  logic        w_supported;
  logic        w_issue;
  logic        w_reject;
  logic [31:0] w_busy_next;

  // x0 is never a real dependency, so it cannot stall.
  assign w_hazard          = instruction_valid && (w_rs1_index != 5'd0) && r_busy[w_rs1_index];
  assign instruction_ready = !w_hazard;
  assign w_accept          = instruction_valid && instruction_ready;

  // Shifts (funct3 1 and 5) live in this opcode but are not handled here.
  assign w_supported = (w_opcode == C_OPCODE_OP_IMM) &&
                       (w_funct3 != 3'd1) && (w_funct3 != 3'd5);
  assign w_issue     = w_accept && w_supported;
  assign w_reject    = w_accept && !w_supported;

  // Scoreboard update: clear from writeback first so that an issue to the
  // same index in the same cycle leaves the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_valid) begin
      w_busy_next[wb_rd] = 1'b0;
    end
    if (w_issue && (w_rd != 5'd0)) begin
      w_busy_next[w_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy         <= '0;
      r_enable       <= 1'b0;
      r_illegal      <= 1'b0;
      r_funct3       <= '0;
      r_rs1          <= '0;
      r_immediate    <= '0;
      r_rd_index     <= '0;
      r_issued_count <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_enable  <= w_issue;
      r_illegal <= w_reject;
      if (w_issue) begin
        r_funct3       <= w_funct3;
        r_rs1          <= (w_rs1_index == 5'd0) ? '0 : rf_read_data;
        r_immediate    <= w_immediate;
        r_rd_index     <= w_rd;
        r_issued_count <= r_issued_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign alu_register_immediate_enable = r_enable;
  assign illegal_instruction           = r_illegal;
  assign funct3                        = r_funct3;
  assign rs1                           = r_rs1;
  assign immediate12_itype             = r_immediate;
  assign rd_index                      = r_rd_index;
  assign issued_count                  = r_issued_count;

endmodule
`default_nettype wire

// File: tb/tb_op_imm_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_op_imm_issue
// Description : Self-checking bench for op_imm_issue. A behavioural model of
//               the scoreboard, operands and counter is advanced once per
//               cycle and compared against the DUT on every falling edge;
//               directed sequences pin the model with literal expectations,
//               followed by randomized traffic with random writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_op_imm_issue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instruction_valid = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        instruction_ready;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_data;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        alu_register_immediate_enable;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] immediate12_itype;
  logic [4:0]  rd_index;
  logic        illegal_instruction;
  logic [31:0] issued_count;

  logic [31:0] rf [32];
  assign rf_read_data = rf[rf_read_address];

  always #5 clock = ~clock;

  op_imm_issue #(.XLEN(32), .COUNT_WIDTH(32)) dut (
    .clock                         (clock),
    .reset_n                       (reset_n),
    .instruction_valid             (instruction_valid),
    .instruction                   (instruction),
    .instruction_ready             (instruction_ready),
    .rf_read_address               (rf_read_address),
    .rf_read_data                  (rf_read_data),
    .wb_valid                      (wb_valid),
    .wb_rd                         (wb_rd),
    .alu_register_immediate_enable (alu_register_immediate_enable),
    .funct3                        (funct3),
    .rs1                           (rs1),
    .immediate12_itype             (immediate12_itype),
    .rd_index                      (rd_index),
    .illegal_instruction           (illegal_instruction),
    .issued_count                  (issued_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [32];
  logic        m_en, m_ill, m_acc;
  logic [2:0]  m_f3;
  logic [31:0] m_rs1, m_imm, m_count;
  logic [4:0]  m_rd;
  logic [4:0]  pend [$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_en = 0; m_ill = 0; m_acc = 0; m_f3 = 0;
    m_rs1 = 0; m_imm = 0; m_count = 0; m_rd = 0;
    pend.delete();
  endtask

  initial begin
    logic [4:0] idx;
    logic       exp_ready, sup;
    int         v;
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        model_reset();
        chk("rst_enable",  alu_register_immediate_enable, 0);
        chk("rst_illegal", illegal_instruction, 0);
        chk("rst_funct3",  funct3, 0);
        chk("rst_rs1",     rs1, 0);
        chk("rst_imm",     immediate12_itype, 0);
        chk("rst_rd",      rd_index, 0);
        chk("rst_count",   issued_count, 0);
      end else begin
        idx = instruction[19:15];
        exp_ready = !(instruction_valid && idx != 0 && m_busy[idx]);
        chk("m_ready",   instruction_ready, exp_ready);
        chk("m_rf_addr", rf_read_address, idx);
        chk("m_enable",  alu_register_immediate_enable, m_en);
        chk("m_illegal", illegal_instruction, m_ill);
        chk("m_funct3",  funct3, m_f3);
        chk("m_rs1",     rs1, m_rs1);
        chk("m_imm",     immediate12_itype, m_imm);
        chk("m_rd",      rd_index, m_rd);
        chk("m_count",   issued_count, m_count);
        // advance to the state after the coming edge
        m_acc = instruction_valid && exp_ready;
        sup = (instruction[6:0] == 7'h13) && (instruction[14:12] != 3'd1) &&
              (instruction[14:12] != 3'd5);
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        m_en  = m_acc && sup;
        m_ill = m_acc && !sup;
        if (m_en) begin
          m_f3  = instruction[14:12];
          m_rs1 = (idx == 0) ? 32'h0 : rf[idx];
          v = int'(instruction[31:20]);
          if (v >= 2048) v -= 4096;
          m_imm = 32'(v);
          m_rd  = instruction[11:7];
          m_count = m_count + 32'd1;
          if (m_rd != 0) begin
            m_busy[m_rd] = 1'b1;
            pend.push_back(m_rd);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance one edge; the register file commits the writeback at that edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd);
    instruction_valid = v;
    instruction       = ins;
    wb_valid          = wv;
    wb_rd             = wr;
    wb_data           = wd;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 11);
    if (k < 9) begin
      w[6:0] = 7'h13;
      case ($urandom_range(0, 5))
        0: w[14:12] = 3'd0;
        1: w[14:12] = 3'd2;
        2: w[14:12] = 3'd3;
        3: w[14:12] = 3'd4;
        4: w[14:12] = 3'd6;
        default: w[14:12] = 3'd7;
      endcase
    end else if (k < 11) begin
      w[6:0] = 7'h13;
      w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
    end else begin
      if (w[6:0] == 7'h13) w[6:0] = 7'h33;
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    rf[1] = 32'h10;

    #1;
    chk("init_ready", instruction_ready, 1);
    chk("init_count", issued_count, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // ADDI x5, x1, -1
    drive(1, 32'hFFF08293, 0, 0, 0);
    step();
    chk("addi_en",    alu_register_immediate_enable, 1);
    chk("addi_f3",    funct3, 0);
    chk("addi_rs1",   rs1, 32'h10);
    chk("addi_imm",   immediate12_itype, 32'hFFFFFFFF);
    chk("addi_rd",    rd_index, 5);
    chk("addi_count", issued_count, 1);
    drive(0, 0, 1, 5, 32'h0);
    step();
    chk("addi_en_drop", alu_register_immediate_enable, 0);

    // RAW: addi x5, x0, 3 then xori x6, x5, 1
    drive(1, 32'h00300293, 0, 0, 0);
    step();
    chk("raw_prod_en", alu_register_immediate_enable, 1);
    chk("raw_prod_imm", immediate12_itype, 3);
    drive(1, 32'h0012C313, 0, 0, 0);
    #1;
    chk("raw_ready_low", instruction_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("raw_stall_en", alu_register_immediate_enable, 0);
      chk("raw_stall_ready", instruction_ready, 0);
    end
    wb_valid = 1; wb_rd = 5; wb_data = 32'hABCD0000;
    step();
    wb_valid = 0;
    #1;
    chk("raw_ready_after_clear", instruction_ready, 1);
    chk("raw_en_at_clear", alu_register_immediate_enable, 0);
    step();
    chk("raw_dep_en",    alu_register_immediate_enable, 1);
    chk("raw_dep_rs1",   rs1, 32'hABCD0000);
    chk("raw_dep_f3",    funct3, 4);
    chk("raw_dep_rd",    rd_index, 6);
    chk("raw_dep_imm",   immediate12_itype, 1);
    chk("raw_dep_count", issued_count, 3);
    drive(0, 0, 0, 0, 0);

    // x0 handling: ori x0, x0, 7 then andi x1, x0, 1
    drive(1, 32'h00706013, 0, 0, 0);
    step();
    chk("x0_en",  alu_register_immediate_enable, 1);
    chk("x0_rs1", rs1, 0);
    chk("x0_rd",  rd_index, 0);
    drive(1, 32'h00107093, 0, 0, 0);
    #1;
    chk("x0_follow_ready", instruction_ready, 1);
    step();
    chk("x0_follow_en", alu_register_immediate_enable, 1);
    drive(0, 0, 1, 1, $urandom);
    step();
    drive(0, 0, 1, 6, $urandom);
    step();
    drive(0, 0, 0, 0, 0);

    // Illegal: slli x1, x1, 2 and an OP (0110011) word
    drive(1, 32'h00209093, 0, 0, 0);
    #1;
    chk("ill_slli_ready", instruction_ready, 1);
    step();
    chk("ill_slli_flag",  illegal_instruction, 1);
    chk("ill_slli_en",    alu_register_immediate_enable, 0);
    chk("ill_slli_count", issued_count, 5);
    drive(1, 32'h003100B3, 0, 0, 0);
    step();
    chk("ill_op_flag",  illegal_instruction, 1);
    chk("ill_op_en",    alu_register_immediate_enable, 0);
    chk("ill_op_count", issued_count, 5);
    chk("ill_op_hold_rd", rd_index, 1);
    drive(0, 0, 0, 0, 0);
    step();
    chk("ill_flag_drop", illegal_instruction, 0);
    drive(1, 32'h00008113, 0, 0, 0);
    #1;
    chk("ill_no_stall", instruction_ready, 1);
    step();
    chk("ill_after_en",    alu_register_immediate_enable, 1);
    chk("ill_after_count", issued_count, 6);

    // Same-edge set/clear on x7
    drive(1, 32'h00000393, 1, 7, 32'h00005555);
    step();
    chk("se_en", alu_register_immediate_enable, 1);
    drive(1, 32'h00038413, 0, 0, 0);
    #1;
    chk("se_ready_low", instruction_ready, 0);
    step();
    chk("se_stall_ready", instruction_ready, 0);
    chk("se_stall_en", alu_register_immediate_enable, 0);
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77770001;
    step();
    wb_valid = 0;
    step();
    chk("se_dep_en",    alu_register_immediate_enable, 1);
    chk("se_dep_rs1",   rs1, 32'h77770001);
    chk("se_dep_rd",    rd_index, 8);
    chk("se_dep_count", issued_count, 8);
    drive(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle while outputs are active
    drive(1, 32'h00500493, 0, 0, 0);
    step();
    chk("ar_pre_en", alu_register_immediate_enable, 1);
    drive(0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_enable",  alu_register_immediate_enable, 0);
    chk("ar_illegal", illegal_instruction, 0);
    chk("ar_funct3",  funct3, 0);
    chk("ar_rs1",     rs1, 0);
    chk("ar_imm",     immediate12_itype, 0);
    chk("ar_rd",      rd_index, 0);
    chk("ar_count",   issued_count, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    // x8 was busy before reset; that must be forgotten
    drive(1, 32'h00040193, 0, 0, 0);
    #1;
    chk("ar_busy_cleared", instruction_ready, 1);
    step();
    chk("ar_post_en",    alu_register_immediate_enable, 1);
    chk("ar_post_count", issued_count, 1);
    drive(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(instruction_valid && !m_acc)) begin
        instruction_valid = ($urandom_range(0, 3) != 0);
        instruction = gen_instr();
      end
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1;
        wb_rd = pend.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        wb_valid = 1;
        wb_rd = 5'($urandom_range(0, 31));
      end else begin
        wb_valid = 0;
      end
      wb_data = $urandom;
      step();
    end

    drive(0, 0, 0, 0, 0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/op_imm_issue.md
# op_imm_issue

Issue stage for RV32I OP-IMM instructions, directly upstream of `alu_register_immediate`. Accepts 32-bit instruction words over a valid/ready handshake, decodes opcode `0010011`, reads rs1 from the register file, and sign-extends imm[11:0]. It then drives the ALU's enable, funct3, rs1 and immediate inputs from registered outputs. A 32-entry busy scoreboard, cleared by writeback, stalls read-after-write hazards. Unsupported encodings are consumed and flagged.

## Interface
Parameters:
- `XLEN`, 32, data width; only 32 is supported.
- `COUNT_WIDTH`, 32, width of `issued_count`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instruction_valid`  in  1  an instruction word is offered.
- `instruction`  in  32  the offered instruction word.
- `instruction_ready`  out  1  the stage accepts `instruction` this cycle (combinational).
- `rf_read_address`  out  5  register-file read index; combinational, equals `instruction[19:15]`.
- `rf_read_data`  in  XLEN  register-file read data; combinational, same cycle.
- `wb_valid`  in  1  writeback commits a result to the register file this cycle.
- `wb_rd`  in  5  register index being written back.
- `alu_register_immediate_enable`  out  1  issue pulse to the ALU.
- `funct3`  out  3  registered `instruction[14:12]`.
- `rs1`  out  XLEN  registered rs1 value.
- `immediate12_itype`  out  XLEN  registered, sign-extended `instruction[31:20]`.
- `rd_index`  out  5  registered `instruction[11:7]`; carried alongside the ALU result to writeback.
- `illegal_instruction`  out  1  one-cycle pulse for an accepted but unsupported word.
- `issued_count`  out  COUNT_WIDTH  number of instructions issued since reset.

## Operation
- **Field decode:** opcode = [6:0], rd = [11:7], funct3 = [14:12], rs1 index = [19:15], immediate = {{20{[31]}}, [31:20]}.
- **Supported:** opcode `0010011` with funct3 in {0, 2, 3, 4, 6, 7}, i.e. ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
- **Unsupported:** any other opcode, or funct3 of 1 or 5 (shifts).
- **Hazard:** `busy[rs1 index]` is set and rs1 index ≠ 0. Evaluated from the instruction fields whenever `instruction_valid` is high.
- **Ready:** `instruction_ready` = !(`instruction_valid` && hazard). Ready is high when no instruction is offered.
- **Accept:** `instruction_valid` && `instruction_ready`. Only an accepted word has any effect.
- **Accepted and supported (issue):**
  - Next cycle: `alu_register_immediate_enable` = 1 and `funct3`/`rs1`/`immediate12_itype`/`rd_index` are loaded.
  - `rs1` takes `rf_read_data`; it is forced to 0 when the rs1 index is 0.
  - `busy[rd]` is set if rd ≠ 0.
  - `issued_count` increments and wraps modulo 2^COUNT_WIDTH.
- **Accepted and unsupported:**
  - Next cycle: `illegal_instruction` = 1 and enable = 0.
  - Data outputs hold their previous values; no busy bit is set; the count is unchanged.
- **No accept:** enable = 0, illegal = 0, data outputs hold.
- **Busy scoreboard:** 32 bits; bit 0 is permanently 0.
  - `wb_valid` clears `busy[wb_rd]` at the clock edge.
  - If an issue sets the same index in the same cycle, the set wins.
  - The scoreboard has no capacity limit: back-to-back issues to distinct rd never stall.
- **Reset (asynchronous, mid-operation allowed):** all outputs 0; `busy` all 0; `issued_count` = 0.
  - An instruction that was accepted and not yet issued is discarded.
  - Writebacks still pending at reset are forgotten.

## Timing
- **Issue latency:** accept at edge E → enable and data valid from E to E+1, for exactly one cycle. The ALU samples at E+1, so its result is available after E+1.
- **Throughput:** one instruction per cycle when there are no hazards.
- **Hazard clear:** a busy bit cleared at edge W releases a stalled dependent at W. Ready rises in the cycle after W and the dependent is accepted at W+1.
  - The register file must have committed the write by W, so the read in the cycle after W sees the new value.
- **Stall hold:** while ready = 0, the upstream holds `instruction` stable. The stage samples nothing.

## Test plan
- **Reset:** assert `reset_n` = 0 asynchronously mid-cycle → all outputs 0 immediately; `issued_count` = 0.
- **ADDI issue:** `addi x5, x1, -1` (0xFFF08293) with `rf_read_data` = 0x10 → next cycle enable = 1, funct3 = 0, rs1 = 0x10, immediate = 0xFFFFFFFF, rd_index = 5, count = 1. Enable is 0 on the following cycle.
- **RAW stall:** issue `addi x5, x0, 3`, then offer `xori x6, x5, 1` → ready = 0 until `wb_valid` with `wb_rd` = 5.
  - The dependent is accepted on the edge after the clear.
  - rs1 equals the written-back value.
- **x0 handling:** `ori x0, x0, 7` issues with rs1 = 0 and sets no busy bit. Immediately following `andi x1, x0, 1` issues without a stall.
- **Illegal:** `slli x1, x1, 2` (0x00209093) and opcode `0110011` → each gives a one-cycle `illegal_instruction`, enable = 0, count unchanged, no stall created.
- **Same-edge set/clear:** `wb_valid` with `wb_rd` = 7 in the same cycle as issuing `addi x7, …` → `busy[7]` remains 1, and a following x7 reader stalls until the next writeback.
